// File: rtl/uart_tx_mmio_if.sv
// CPU data-memory bus bundle (store strobe, byte address, store data, load data).
// master: CPU side drives WE/A/WD and receives RD.
// slave : memory-mapped responder receives WE/A/WD and returns RD one cycle later.
interface uart_tx_mmio_if;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;

  modport master (output WE, A, WD, input RD);
  modport slave  (input WE, A, WD, output RD);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter sitting on the CPU data-memory bus like dmem.
// Latency: loads return on RD one clock after the address is presented; a byte stored
// to an idle transmitter starts its start bit one clock after the store edge.
// Backpressure: none on the bus; a store into a full FIFO is dropped and flags overflow.
// Ports: clk/rst (sync, active-high), bus (WE/A/WD in, RD out), tx (idle high), irq.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_mmio_if.slave      bus,
  output logic               tx,
  output logic               irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  // Configuration
  logic [15:0]   baud_q, baud_d;

  // Transmit FSM
  logic [1:0]    state_q, state_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  // Read path
  logic [31:0]   rd_q, rd_d;

  logic          hit;
  logic [1:0]    off;
  logic          push, push_ok, pop;
  logic          empty, full, busy, bit_end;
  logic [7:0]    head;
  logic [7:0]    cnt8;
  logic          unused_bits;

  assign hit     = (bus.A[31:4] == BASE_ADDR[31:4]);
  assign off     = bus.A[3:2];
  assign push    = bus.WE & hit & (off == 2'd0);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign busy    = (state_q != S_IDLE);
  assign head    = mem_q[rd_ptr_q];
  assign cnt8    = 8'(cnt_q);
  assign bit_end = (bcnt_q == div_q - 16'd1);
  // A full FIFO still takes a store if the FSM frees a slot on the same edge.
  assign push_ok = push & (~full | pop);

  assign unused_bits = ^{bus.A[1:0], bus.WD[31:16]};

  // Transmit FSM: tx_d is the line level for the cycle after this edge.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          div_d   = baud_q;
          bcnt_d  = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bcnt_d  = '0;
          bidx_d  = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (bidx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bidx_d  = bidx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (!empty) begin
            // Chain straight into the next start bit; divider re-latched per frame.
            pop     = 1'b1;
            shift_d = head;
            div_d   = baud_q;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointers, count, overflow flag and divider register
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    baud_d   = baud_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end else if (bus.WE && hit && (off == 2'd1) && bus.WD[3]) begin
      ovf_d = 1'b0;
    end
    if (bus.WE && hit && (off == 2'd2)) begin
      baud_d = (bus.WD[15:0] == 16'd0) ? 16'd1 : bus.WD[15:0];
    end
  end

  // Load data reflects register contents before the edge that captures it.
  always_comb begin
    rd_d = '0;
    if (hit) begin
      case (off)
        2'd1:    rd_d = {16'h0, cnt8, 4'h0, ovf_q, empty, full, busy};
        2'd2:    rd_d = {16'h0, baud_q};
        default: rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.WD[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      baud_q   <= DIV_RESET;
      state_q  <= S_IDLE;
      div_q    <= DIV_RESET;
      bcnt_q   <= '0;
      bidx_q   <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      baud_q   <= baud_d;
      state_q  <= state_d;
      div_q    <= div_d;
      bcnt_q   <= bcnt_d;
      bidx_q   <= bidx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.RD = rd_q;
  assign tx     = tx_q;
  assign irq    = empty & (state_q == S_IDLE);

endmodule
